// File: rtl/led_mode_ctrl_pkg.sv
// Shared LED mode encoding and mode-sequencing helpers for the blinker and status logic.
package led_mode_ctrl_pkg;

   typedef enum logic [1:0] {
      ModeOff  = 2'd0,
      ModeOn   = 2'd1,
      ModeSlow = 2'd2,
      ModeFast = 2'd3
   } mode_e;

   function automatic mode_e next_mode(input mode_e cur);
      unique case (cur)
         ModeOff:  next_mode = ModeOn;
         ModeOn:   next_mode = ModeSlow;
         ModeSlow: next_mode = ModeFast;
         default:  next_mode = ModeOff;
      endcase
   endfunction

   function automatic logic is_blink(input mode_e m);
      is_blink = (m == ModeSlow) || (m == ModeFast);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Half-period divider: counts 0..div-1 while enabled and pulses tick on each wrap.
// term flags the wrapping edge so the owner can update its own register in step with tick.
module tick_gen #(
   parameter int unsigned CNT_W = 27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] div,
   output logic             tick,
   output logic             term
);

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             tick_d, tick_q;

   assign term = en && !clr && (cnt_q == div - CNT_W'(1));

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: steps OFF->ON->SLOW->FAST on button pulses and drives a
// registered LED from a shared divider whose ratio follows the current mode.
module led_mode_ctrl
   import led_mode_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned SLOW_HZ = 1,
   parameter int unsigned FAST_HZ = 4,
   parameter int unsigned CNT_W   = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       pause,
   output logic       led,
   output logic [1:0] mode,
   output logic       tick
);

   localparam int unsigned DivSlow = CLK_HZ / (2 * SLOW_HZ);
   localparam int unsigned DivFast = CLK_HZ / (2 * FAST_HZ);

   if (DivSlow < 2 || (DivSlow >> CNT_W) != 0) begin : gen_bad_div_slow
      $error("led_mode_ctrl: slow divider out of range for CNT_W");
   end
   if (DivFast < 2 || (DivFast >> CNT_W) != 0) begin : gen_bad_div_fast
      $error("led_mode_ctrl: fast divider out of range for CNT_W");
   end

   mode_e            mode_d, mode_q;
   logic             led_d, led_q;
   logic             cnt_en;
   logic             term;
   logic [CNT_W-1:0] div;

   assign cnt_en = is_blink(mode_q) && !pause;
   assign div    = (mode_q == ModeFast) ? CNT_W'(DivFast) : CNT_W'(DivSlow);

   // A button edge wins over a coinciding terminal count; term is already masked by clr.
   always_comb begin
      mode_d = mode_q;
      led_d  = led_q;
      if (btn_mode) begin
         mode_d = next_mode(mode_q);
         led_d  = (next_mode(mode_q) != ModeOff);
      end else if (term) begin
         led_d = !led_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= ModeOff;
         led_q  <= 1'b0;
      end else begin
         mode_q <= mode_d;
         led_q  <= led_d;
      end
   end

   tick_gen #(
      .CNT_W (CNT_W)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (btn_mode),
      .en   (cnt_en),
      .div  (div),
      .tick (tick),
      .term (term)
   );

   assign led  = led_q;
   assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with a 16 Hz clock: slow half-period 8, fast 2.
module tb_led_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode;
   logic       pause;
   logic       led;
   logic [1:0] mode;
   logic       tick;

   int n_tests = 0;
   int n_fail  = 0;

   led_mode_ctrl #(
      .CLK_HZ  (16),
      .SLOW_HZ (1),
      .FAST_HZ (4),
      .CNT_W   (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_mode (btn_mode),
      .pause    (pause),
      .led      (led),
      .mode     (mode),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; btn_mode = 1'b0; pause = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic press();
      btn_mode = 1'b1;
      step();
      btn_mode = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode got %0d want 0", mode); end
      n_tests++;
      if (led !== 1'b0) begin n_fail++; $display("FAIL reset_led got %b want 0", led); end
      n_tests++;
      if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
      for (int i = 0; i < 40; i++) begin
         step();
         n_tests++;
         if (mode !== 2'd0 || led !== 1'b0 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle cyc %0d got mode=%0d led=%b tick=%b want 0/0/0",
                     i, mode, led, tick);
         end
      end
   endtask

   task automatic test_mode_walk();
      logic [1:0] exp_mode [4];
      logic       exp_led  [4];
      exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0};
      exp_led  = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         press();
         n_tests++;
         if (mode !== exp_mode[i] || led !== exp_led[i] || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_walk %0d got mode=%0d led=%b tick=%b want mode=%0d led=%b tick=0",
                     i, mode, led, tick, exp_mode[i], exp_led[i]);
         end
         for (int j = 0; j < 9; j++) step();
      end
   endtask

   task automatic test_slow_blink();
      logic exp_led;
      do_reset();
      press();
      press();
      exp_led = 1'b1;
      for (int k = 0; k < 4; k++) begin
         for (int j = 1; j < 8; j++) begin
            step();
            n_tests++;
            if (tick !== 1'b0 || led !== exp_led) begin
               n_fail++;
               $display("FAIL slow_hold toggle %0d cyc %0d got led=%b tick=%b want led=%b tick=0",
                        k, j, led, tick, exp_led);
            end
         end
         step();
         exp_led = !exp_led;
         n_tests++;
         if (tick !== 1'b1 || led !== exp_led || mode !== 2'd2) begin
            n_fail++;
            $display("FAIL slow_toggle %0d got led=%b tick=%b mode=%0d want led=%b tick=1 mode=2",
                     k, led, tick, mode, exp_led);
         end
      end
   endtask

   task automatic test_fast_blink();
      logic exp_led;
      logic prev_tick;
      do_reset();
      press();
      press();
      press();
      n_tests++;
      if (mode !== 2'd3 || led !== 1'b1) begin
         n_fail++;
         $display("FAIL fast_entry got mode=%0d led=%b want mode=3 led=1", mode, led);
      end
      exp_led   = 1'b1;
      prev_tick = tick;
      for (int j = 1; j <= 12; j++) begin
         step();
         if (j % 2 == 0) exp_led = !exp_led;
         n_tests++;
         if (tick !== (j % 2 == 0) || led !== exp_led || (tick && prev_tick)) begin
            n_fail++;
            $display("FAIL fast_blink cyc %0d got led=%b tick=%b want led=%b tick=%b",
                     j, led, tick, exp_led, (j % 2 == 0));
         end
         prev_tick = tick;
      end
   endtask

   task automatic test_pause();
      do_reset();
      press();
      press();
      for (int j = 0; j < 5; j++) step();
      pause = 1'b1;
      for (int j = 0; j < 20; j++) begin
         step();
         n_tests++;
         if (led !== 1'b1 || tick !== 1'b0 || mode !== 2'd2) begin
            n_fail++;
            $display("FAIL pause_hold cyc %0d got led=%b tick=%b mode=%0d want led=1 tick=0 mode=2",
                     j, led, tick, mode);
         end
      end
      pause = 1'b0;
      for (int j = 1; j <= 2; j++) begin
         step();
         n_tests++;
         if (led !== 1'b1 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_resume cyc %0d got led=%b tick=%b want led=1 tick=0",
                     j, led, tick);
         end
      end
      step();
      n_tests++;
      if (led !== 1'b0 || tick !== 1'b1) begin
         n_fail++;
         $display("FAIL pause_toggle got led=%b tick=%b want led=0 tick=1", led, tick);
      end
   endtask

   task automatic test_collision_reset();
      do_reset();
      press();
      press();
      for (int j = 0; j < 7; j++) step();
      press();
      n_tests++;
      if (mode !== 2'd3 || led !== 1'b1 || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL collision got mode=%0d led=%b tick=%b want mode=3 led=1 tick=0",
                  mode, led, tick);
      end
      step();
      n_tests++;
      if (led !== 1'b1 || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL collision_restart got led=%b tick=%b want led=1 tick=0", led, tick);
      end
      for (int j = 0; j < 3; j++) step();
      n_tests++;
      if (led !== 1'b1 || tick !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_blink got led=%b tick=%b want led=1 tick=1", led, tick);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++;
      if (mode !== 2'd0 || led !== 1'b0 || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_blink_reset got mode=%0d led=%b tick=%b want 0/0/0", mode, led, tick);
      end
   endtask

   initial begin
      rst = 1'b1; btn_mode = 1'b0; pause = 1'b0;
      test_reset();
      test_mode_walk();
      test_slow_blink();
      test_fast_blink();
      test_pause();
      test_collision_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
